// File: rtl/cpu16_mem_pkg.sv
// cpu16_mem_pkg: shared definitions for the cpu16 memory arbiter.
//   Region codes for address bits [15:12] and the source tag that
//   records which requester owns the result returning in the next cycle.
package cpu16_mem_pkg;

  localparam logic [3:0] REG_SRAM = 4'h0;
  localparam logic [3:0] REG_VRAM = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hF;

  typedef enum logic [1:0] {
    SrcNone,
    SrcIns,
    SrcDatSram,
    SrcDatReg
  } src_t;

  function automatic logic [3:0] region_of(input logic [15:0] addr);
    return addr[15:12];
  endfunction

endpackage

// File: rtl/cpu16_mem_arb.sv
// cpu16_mem_arb: responder end of the cpu16 req/rdy memory interface.
//   Arbitrates instruction fetches, data reads and data writes from the CPU,
//   plus unhandshaked debug writes, onto one sram read port, one write path
//   (sram/vram/ctrl) and returns per-port rdy pulses with steered read data.
// Ports:
//   clk, reset                      clock, synchronous active-high reset (CPU side only)
//   ins_rd_*                        instruction fetch req/addr -> rdy/data
//   dat_rw_addr, dat_rd_*, dat_wr_* data read/write req/data -> rdy/data
//   dbg_we/waddr/wdata              debug write strobe, always honoured
//   mem_raddr/re/rdata              sram read port (rdata one cycle after re)
//   mem_waddr/wdata/we              sram write port
//   vram_waddr/wdata/we             vram write port
//   ctrl_we, ctrl_rdata             ctrl register write strobe (data on mem_wdata) and read value
module cpu16_mem_arb
  import cpu16_mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [15:0] FILL_DATA    = 16'hEEEE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ins_rd_addr,
  input  logic        ins_rd_req,
  output logic        ins_rd_rdy,
  output logic [15:0] ins_rd_data,
  input  logic [15:0] dat_rw_addr,
  input  logic        dat_rd_req,
  output logic        dat_rd_rdy,
  output logic [15:0] dat_rd_data,
  input  logic        dat_wr_req,
  input  logic [15:0] dat_wr_data,
  output logic        dat_wr_rdy,
  input  logic        dbg_we,
  input  logic [15:0] dbg_waddr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] mem_raddr,
  output logic        mem_re,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        ctrl_we,
  input  logic [15:0] ctrl_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] starve_q, starve_d;
  src_t            tag_q, tag_d;
  logic            ins_rdy_q, dwr_rdy_q;
  logic [15:0]     dat_reg_q, dat_reg_d;
  logic [15:0]     ins_hold_q, dat_hold_q;

  logic        cpu_ok, dat_rd_live, dat_rd_sram, ins_first;
  logic        gnt_ins, gnt_dsram, gnt_dreg, gnt_dwr;
  logic        wr_go;
  logic [15:0] wr_addr, wr_data;
  logic [3:0]  wr_region;

  // Arbitration
  always_comb begin
    cpu_ok      = ~reset;
    // A simultaneous write wins; the read just stalls.
    dat_rd_live = dat_rd_req & ~dat_wr_req;
    dat_rd_sram = dat_rd_live & (region_of(dat_rw_addr) == REG_SRAM);
    ins_first   = (starve_q == StarveMax);
    gnt_ins     = cpu_ok & ins_rd_req & (~dat_rd_sram | ins_first);
    gnt_dsram   = cpu_ok & dat_rd_sram & ~gnt_ins;
    // Register-sourced reads bypass the sram port and run alongside fetches.
    gnt_dreg    = cpu_ok & dat_rd_live & ~dat_rd_sram;
    gnt_dwr     = cpu_ok & dat_wr_req & ~dbg_we;

    starve_d = starve_q;
    if (gnt_ins) begin
      starve_d = '0;
    end else if (cpu_ok && ins_rd_req && starve_q != StarveMax) begin
      starve_d = starve_q + 1'b1;
    end

    tag_d = SrcNone;
    if (gnt_dsram) begin
      tag_d = SrcDatSram;
    end else if (gnt_dreg) begin
      tag_d = SrcDatReg;
    end else if (gnt_ins) begin
      tag_d = SrcIns;
    end

    dat_reg_d = dat_reg_q;
    if (gnt_dreg) begin
      dat_reg_d = (region_of(dat_rw_addr) == REG_CTRL) ? ctrl_rdata : FILL_DATA;
    end
  end

  // Read port
  always_comb begin
    mem_re    = gnt_ins | gnt_dsram;
    mem_raddr = gnt_ins ? ins_rd_addr : dat_rw_addr;
  end

  // Write path: debug strobe has priority; unmapped writes enable nothing.
  always_comb begin
    wr_go      = dbg_we | gnt_dwr;
    wr_addr    = dbg_we ? dbg_waddr : dat_rw_addr;
    wr_data    = dbg_we ? dbg_wdata : dat_wr_data;
    wr_region  = region_of(wr_addr);
    mem_we     = wr_go & (wr_region == REG_SRAM);
    vram_we    = wr_go & (wr_region == REG_VRAM);
    ctrl_we    = wr_go & (wr_region == REG_CTRL);
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    vram_waddr = wr_addr[10:0];
    vram_wdata = wr_data[7:0];
  end

  // Responses; gating with reset drops rdy for a grant made just before reset.
  always_comb begin
    ins_rd_rdy  = ins_rdy_q & ~reset;
    dat_rd_rdy  = ((tag_q == SrcDatSram) || (tag_q == SrcDatReg)) & ~reset;
    dat_wr_rdy  = dwr_rdy_q & ~reset;
    ins_rd_data = ins_rd_rdy ? mem_rdata : ins_hold_q;
    dat_rd_data = dat_hold_q;
    if (dat_rd_rdy) begin
      dat_rd_data = (tag_q == SrcDatSram) ? mem_rdata : dat_reg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (ins_rd_rdy) ins_hold_q <= mem_rdata;
    if (dat_rd_rdy) dat_hold_q <= dat_rd_data;
    if (reset) begin
      starve_q  <= '0;
      tag_q     <= SrcNone;
      ins_rdy_q <= 1'b0;
      dwr_rdy_q <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      tag_q     <= tag_d;
      ins_rdy_q <= gnt_ins;
      dwr_rdy_q <= gnt_dwr;
      dat_reg_q <= dat_reg_d;
    end
  end

endmodule

// File: tb/tb_cpu16_mem_arb.sv
// Testbench for cpu16_mem_arb: sram model plus scoreboard queues of expected
// rdy cycles and data, popped by a monitor whenever a rdy pulse appears.
module tb_cpu16_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ins_rd_addr, dat_rw_addr, dat_wr_data, dbg_waddr, dbg_wdata, ctrl_rdata;
  logic        ins_rd_req, dat_rd_req, dat_wr_req, dbg_we;
  logic        ins_rd_rdy, dat_rd_rdy, dat_wr_rdy;
  logic [15:0] ins_rd_data, dat_rd_data;
  logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic        mem_re, mem_we, vram_we, ctrl_we;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  exp_t ins_q[$];
  exp_t drd_q[$];
  int   dwr_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [15:0] sram [256];

  cpu16_mem_arb dut (
    .clk        (clk),
    .reset      (reset),
    .ins_rd_addr(ins_rd_addr),
    .ins_rd_req (ins_rd_req),
    .ins_rd_rdy (ins_rd_rdy),
    .ins_rd_data(ins_rd_data),
    .dat_rw_addr(dat_rw_addr),
    .dat_rd_req (dat_rd_req),
    .dat_rd_rdy (dat_rd_rdy),
    .dat_rd_data(dat_rd_data),
    .dat_wr_req (dat_wr_req),
    .dat_wr_data(dat_wr_data),
    .dat_wr_rdy (dat_wr_rdy),
    .dbg_we     (dbg_we),
    .dbg_waddr  (dbg_waddr),
    .dbg_wdata  (dbg_wdata),
    .mem_raddr  (mem_raddr),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .ctrl_we    (ctrl_we),
    .ctrl_rdata (ctrl_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous sram: read-before-write on the same edge returns old data.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= sram[mem_raddr[7:0]];
    if (mem_we) sram[mem_waddr[7:0]] <= mem_wdata;
  end

  exp_t ei, ed;
  int   ew;

  always @(negedge clk) begin
    if (ins_rd_rdy) begin
      n_chk++;
      if (ins_q.size() == 0) begin
        $display("FAIL ins_rdy_unexpected: cycle %0d got rdy=1 want 0", cyc);
      end else begin
        ei = ins_q.pop_front();
        if (cyc !== ei.cyc || ins_rd_data !== ei.data)
          $display("FAIL ins_rd: got cycle %0d data %h want cycle %0d data %h",
                   cyc, ins_rd_data, ei.cyc, ei.data);
        else n_pass++;
      end
    end
    if (dat_rd_rdy) begin
      n_chk++;
      if (drd_q.size() == 0) begin
        $display("FAIL drd_rdy_unexpected: cycle %0d got rdy=1 want 0", cyc);
      end else begin
        ed = drd_q.pop_front();
        if (cyc !== ed.cyc || dat_rd_data !== ed.data)
          $display("FAIL dat_rd: got cycle %0d data %h want cycle %0d data %h",
                   cyc, dat_rd_data, ed.cyc, ed.data);
        else n_pass++;
      end
    end
    if (dat_wr_rdy) begin
      n_chk++;
      if (dwr_q.size() == 0) begin
        $display("FAIL dwr_rdy_unexpected: cycle %0d got rdy=1 want 0", cyc);
      end else begin
        ew = dwr_q.pop_front();
        if (cyc !== ew) $display("FAIL dat_wr: got cycle %0d want cycle %0d", cyc, ew);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0010;
    dat_rd_req = 1'b0; dat_wr_req = 1'b1; dat_rw_addr = 16'h0001; dat_wr_data = 16'h1111;
    dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; ctrl_rdata = 16'h0000;
    tick(); tick();
    n_chk++;
    if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re, mem_we} !== 5'b0)
      $display("FAIL reset_quiet: got rdy/re/we %b want 00000",
               {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re, mem_we});
    else n_pass++;
    ins_rd_req = 1'b0; dat_wr_req = 1'b0;
    // Preload through the debug port while still in reset.
    for (int i = 0; i < 5; i++) begin
      dbg_we    = 1'b1;
      dbg_waddr = (i < 4) ? 16'h0010 + 16'(i) : 16'h0020;
      dbg_wdata = (i < 4) ? 16'h00A0 + 16'(i) : 16'h5555;
      #1;
      n_chk++;
      if (mem_we !== 1'b1 || mem_waddr !== dbg_waddr || mem_wdata !== dbg_wdata)
        $display("FAIL dbg_in_reset: got we %b addr %h data %h want 1 %h %h",
                 mem_we, mem_waddr, mem_wdata, dbg_waddr, dbg_wdata);
      else n_pass++;
      tick();
    end
    dbg_we = 1'b0;
    reset  = 1'b0;
    tick();
  endtask

  task automatic test_fetch_stream();
    ins_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ins_rd_addr = 16'h0010 + 16'(i);
      ins_q.push_back('{cyc: cyc + 1, data: 16'h00A0 + 16'(i)});
      tick();
    end
    ins_rd_req = 1'b0;
    tick();
    n_chk++;
    if (ins_q.size() != 0) $display("FAIL fetch_stream: got %0d pending want 0", ins_q.size());
    else n_pass++;
  endtask

  task automatic test_dat_priority();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0010;
    dat_rd_req = 1'b1; dat_rw_addr = 16'h0020;
    drd_q.push_back('{cyc: cyc + 1, data: 16'h5555});
    ins_q.push_back('{cyc: cyc + 2, data: 16'h00A0});
    tick();
    dat_rd_req = 1'b0;
    tick();
    ins_rd_req = 1'b0;
    tick();
    n_chk++;
    if (ins_q.size() + drd_q.size() != 0)
      $display("FAIL dat_priority: got %0d pending want 0", ins_q.size() + drd_q.size());
    else n_pass++;
  endtask

  task automatic test_starvation();
    logic [15:0] daddr [7];
    daddr = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0020, 16'h0020, 16'h0000};
    for (int i = 0; i < 4; i++) drd_q.push_back('{cyc: cyc + 1 + i, data: 16'h00A0 + 16'(i)});
    ins_q.push_back('{cyc: cyc + 5, data: 16'h00A2});
    drd_q.push_back('{cyc: cyc + 6, data: 16'h5555});
    ins_rd_addr = 16'h0012;
    for (int i = 0; i < 7; i++) begin
      dat_rd_req  = (i < 6);
      ins_rd_req  = (i < 5);
      dat_rw_addr = daddr[i];
      tick();
    end
    tick();
    n_chk++;
    if (ins_q.size() + drd_q.size() != 0)
      $display("FAIL starvation: got %0d pending want 0", ins_q.size() + drd_q.size());
    else n_pass++;
  endtask

  task automatic test_write_arb();
    dbg_we = 1'b1; dbg_waddr = 16'h8005; dbg_wdata = 16'h0041;
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0003; dat_wr_data = 16'h1234;
    dwr_q.push_back(cyc + 2);
    #1;
    n_chk++;
    if (vram_we !== 1'b1 || vram_waddr !== 11'd5 || vram_wdata !== 8'h41 || mem_we !== 1'b0)
      $display("FAIL dbg_vram: got we %b addr %h data %h mem_we %b want 1 005 41 0",
               vram_we, vram_waddr, vram_wdata, mem_we);
    else n_pass++;
    tick();
    dbg_we = 1'b0;
    #1;
    n_chk++;
    if (mem_we !== 1'b1 || mem_waddr !== 16'h0003 || mem_wdata !== 16'h1234 || vram_we !== 1'b0)
      $display("FAIL dat_wr_sram: got we %b addr %h data %h want 1 0003 1234",
               mem_we, mem_waddr, mem_wdata);
    else n_pass++;
    tick();
    dat_wr_req = 1'b0;
    dat_rd_req = 1'b1;
    drd_q.push_back('{cyc: cyc + 1, data: 16'h1234});
    tick();
    dat_rd_req = 1'b0;
    tick();
    n_chk++;
    if (dwr_q.size() + drd_q.size() != 0)
      $display("FAIL write_arb: got %0d pending want 0", dwr_q.size() + drd_q.size());
    else n_pass++;
  endtask

  task automatic test_same_addr();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0003;
    dat_wr_req = 1'b1; dat_rw_addr = 16'h0003; dat_wr_data = 16'h9999;
    ins_q.push_back('{cyc: cyc + 1, data: 16'h1234});
    dwr_q.push_back(cyc + 1);
    tick();
    ins_rd_req = 1'b0; dat_wr_req = 1'b0; dat_rd_req = 1'b1;
    drd_q.push_back('{cyc: cyc + 1, data: 16'h9999});
    tick();
    dat_rd_req = 1'b0;
    tick();
    n_chk++;
    if (ins_q.size() + dwr_q.size() + drd_q.size() != 0)
      $display("FAIL same_addr: got %0d pending want 0", ins_q.size() + dwr_q.size() + drd_q.size());
    else n_pass++;
  endtask

  task automatic test_reg_reads();
    ctrl_rdata = 16'h0001;
    dat_rd_req = 1'b1; dat_rw_addr = 16'h8000;
    drd_q.push_back('{cyc: cyc + 1, data: 16'hEEEE});
    tick();
    dat_rw_addr = 16'hF000;
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0013;
    drd_q.push_back('{cyc: cyc + 1, data: 16'h0001});
    ins_q.push_back('{cyc: cyc + 1, data: 16'h00A3});
    tick();
    dat_rd_req = 1'b0; ins_rd_req = 1'b0;
    ctrl_rdata = 16'h7777;
    tick();
    n_chk++;
    if (dat_rd_data !== 16'h0001) $display("FAIL drd_hold: got %h want 0001", dat_rd_data);
    else n_pass++;
    n_chk++;
    if (ins_q.size() + drd_q.size() != 0)
      $display("FAIL reg_reads: got %0d pending want 0", ins_q.size() + drd_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    ins_rd_req = 1'b1; ins_rd_addr = 16'h0010;
    tick();
    reset = 1'b1;
    dbg_we = 1'b1; dbg_waddr = 16'h0007; dbg_wdata = 16'hBEEF;
    #1;
    n_chk++;
    if (ins_rd_rdy !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b1 || mem_waddr !== 16'h0007)
      $display("FAIL reset_suppress: got rdy %b re %b we %b addr %h want 0 0 1 0007",
               ins_rd_rdy, mem_re, mem_we, mem_waddr);
    else n_pass++;
    tick();
    dbg_we = 1'b0;
    n_chk++;
    if ({ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re} !== 4'b0)
      $display("FAIL reset_hold: got rdy/re %b want 0000",
               {ins_rd_rdy, dat_rd_rdy, dat_wr_rdy, mem_re});
    else n_pass++;
    tick();
    reset = 1'b0; ins_rd_req = 1'b0;
    dat_rd_req = 1'b1; dat_rw_addr = 16'h0007;
    drd_q.push_back('{cyc: cyc + 1, data: 16'hBEEF});
    tick();
    dat_rd_req = 1'b0;
    tick();
    n_chk++;
    if (ins_q.size() + drd_q.size() != 0)
      $display("FAIL reset_mid: got %0d pending want 0", ins_q.size() + drd_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_dat_priority();
    test_starvation();
    test_write_arb();
    test_same_addr();
    test_reg_reads();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
